// File: rtl/multi_stage_alu_p.sv
// multi_stage_alu_p: A/G staged ALU with registered status flags and an
// iterative shift-add multiplier that reports Busy/Done to the controller.
module multi_stage_alu_p #(
    parameter int WIDTH = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] OP,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    input  logic [3:0]       FN,
    output logic [WIDTH-1:0] RES,
    output logic             Busy,
    output logic             Done,
    output logic             Zf,
    output logic             Nf,
    output logic             Cf,
    output logic             Vf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, vf_q, vf_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_wg, alu_wf;
    logic [2*WIDTH-1:0] mac_sum;

    // Single-cycle function unit: result, carry/overflow and which of G/flags to write
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, OP};
        diff    = {1'b0, a_q} - {1'b0, OP};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wg  = 1'b0;
        alu_wf  = 1'b0;
        case (FN)
            4'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == OP[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                alu_wg  = 1'b1;
                alu_wf  = 1'b1;
            end
            4'd1, 4'd11: begin
                // CMP shares the subtract path but leaves G alone
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a_q[WIDTH-1] != OP[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
                alu_wg  = (FN == 4'd1);
                alu_wf  = 1'b1;
            end
            4'd2:  begin alu_res = a_q & OP; alu_wg = 1'b1; alu_wf = 1'b1; end
            4'd3:  begin alu_res = a_q | OP; alu_wg = 1'b1; alu_wf = 1'b1; end
            4'd4:  begin alu_res = a_q ^ OP; alu_wg = 1'b1; alu_wf = 1'b1; end
            4'd5:  begin alu_res = ~OP;      alu_wg = 1'b1; alu_wf = 1'b1; end
            4'd6: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
                alu_wg  = 1'b1;
                alu_wf  = 1'b1;
            end
            4'd7: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
                alu_wg  = 1'b1;
                alu_wf  = 1'b1;
            end
            4'd8: begin
                alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
                alu_wg  = 1'b1;
                alu_wf  = 1'b1;
            end
            4'd10: begin alu_res = OP; alu_wg = 1'b1; alu_wf = 1'b1; end
            default: begin
                // MUL is handled by the sequencer; 12-15 are silent no-ops
                alu_wg = 1'b0;
                alu_wf = 1'b0;
            end
        endcase
    end

    // Next-state logic for the A/G registers, flags and the multiply sequencer
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        g_d      = g_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        cf_d     = cf_q;
        vf_d     = vf_q;
        done_d   = 1'b0;
        mac_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            S_IDLE: begin
                if (Ain) a_d = OP;
                if (Gin) begin
                    if (FN == 4'd9) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, a_q};
                        mplier_d = OP;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                    end else begin
                        if (alu_wg) g_d = alu_res;
                        if (alu_wf) begin
                            zf_d = (alu_res == '0);
                            nf_d = alu_res[WIDTH-1];
                            cf_d = alu_c;
                            vf_d = alu_v;
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d    = mac_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    g_d     = mac_sum[WIDTH-1:0];
                    zf_d    = (mac_sum[WIDTH-1:0] == '0);
                    nf_d    = mac_sum[WIDTH-1];
                    cf_d    = |mac_sum[2*WIDTH-1:WIDTH];
                    vf_d    = 1'b0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any multiply in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            g_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            g_q      <= g_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
            vf_q     <= vf_d;
            done_q   <= done_d;
        end
    end

    // Output drive: RES is gated by Gout, status comes straight from registers
    always_comb begin
        RES  = Gout ? g_q : '0;
        Busy = (state_q == S_MUL);
        Done = done_q;
        Zf   = zf_q;
        Nf   = nf_q;
        Cf   = cf_q;
        Vf   = vf_q;
    end

endmodule

// File: tb/tb_multi_stage_alu_p.sv
// Bench for multi_stage_alu_p: directed test-plan sequence with literal
// expectations, then random traffic, all cross-checked every cycle against
// an arithmetic reference model.
module tb_multi_stage_alu_p;

    localparam int W    = 10;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [W-1:0] OP    = '0;
    logic         Ain   = 1'b0;
    logic         Gin   = 1'b0;
    logic         Gout  = 1'b0;
    logic [3:0]   FN    = '0;
    logic [W-1:0] RES;
    logic         Busy, Done, Zf, Nf, Cf, Vf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    multi_stage_alu_p #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .OP(OP), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .FN(FN), .RES(RES), .Busy(Busy), .Done(Done),
        .Zf(Zf), .Nf(Nf), .Cf(Cf), .Vf(Vf)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        int a;
        int g;
        bit z, n, c, v;
        int busy;   // multiply edges still to go
        int pend;   // full product waiting to land
        bit done;
    } mstate_t;

    mstate_t m;

    function automatic int sx(input int x);
        return (x >= HALF) ? x - (1 << W) : x;
    endfunction

    function automatic bit sovf(input int s);
        return (s > HALF - 1) || (s < -HALF);
    endfunction

    // Reference: what one clock edge does to the architectural state
    function automatic mstate_t model_step(input mstate_t s, input bit ain, input bit gin,
                                           input int fn, input int b);
        mstate_t t;
        int r;
        bit c, v, wg, wf;
        t = s;
        t.done = 1'b0;
        r = 0; c = 1'b0; v = 1'b0; wg = 1'b0; wf = 1'b0;
        if (s.busy > 0) begin
            t.busy = s.busy - 1;
            if (t.busy == 0) begin
                t.g    = s.pend & MASK;
                t.z    = (t.g == 0);
                t.n    = (t.g >= HALF);
                t.c    = ((s.pend >> W) != 0);
                t.v    = 1'b0;
                t.done = 1'b1;
            end
        end else begin
            if (gin) begin
                case (fn)
                    0:  begin r = s.a + b; c = (r > MASK); v = sovf(sx(s.a) + sx(b)); wg = 1; wf = 1; end
                    1:  begin r = s.a - b; c = (s.a >= b); v = sovf(sx(s.a) - sx(b)); wg = 1; wf = 1; end
                    2:  begin r = s.a & b; wg = 1; wf = 1; end
                    3:  begin r = s.a | b; wg = 1; wf = 1; end
                    4:  begin r = s.a ^ b; wg = 1; wf = 1; end
                    5:  begin r = MASK - b; wg = 1; wf = 1; end
                    6:  begin r = s.a * 2; c = (s.a >= HALF); wg = 1; wf = 1; end
                    7:  begin r = s.a / 2; c = s.a[0]; wg = 1; wf = 1; end
                    8:  begin r = sx(s.a) >>> 1; c = s.a[0]; wg = 1; wf = 1; end
                    9:  begin t.busy = W; t.pend = s.a * b; end
                    10: begin r = b; wg = 1; wf = 1; end
                    11: begin r = s.a - b; c = (s.a >= b); v = sovf(sx(s.a) - sx(b)); wf = 1; end
                    default: ;
                endcase
                r = r & MASK;
                if (wg) t.g = r;
                if (wf) begin
                    t.z = (r == 0);
                    t.n = (r >= HALF);
                    t.c = c;
                    t.v = v;
                end
            end
            if (ain) t.a = b;
        end
        return t;
    endfunction

    // Reference state advances on the same edges as the DUT
    always @(posedge Clock or posedge Reset) begin
        if (Reset) m <= '0;
        else       m <= model_step(m, Ain, Gin, int'(FN), int'(OP));
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference
    always @(negedge Clock) begin
        if (chk_en) begin
            check("model_RES",  int'(RES),  Gout ? m.g : 0);
            check("model_Busy", int'(Busy), int'(m.busy > 0));
            check("model_Done", int'(Done), int'(m.done));
            check("model_Zf",   int'(Zf),   int'(m.z));
            check("model_Nf",   int'(Nf),   int'(m.n));
            check("model_Cf",   int'(Cf),   int'(m.c));
            check("model_Vf",   int'(Vf),   int'(m.v));
        end
    end

    // Drive one cycle's inputs, let the edge pass, return just after the falling edge
    task automatic step(input bit ain, input bit gin, input int fn, input int op);
        Ain = ain;
        Gin = gin;
        FN  = 4'(fn);
        OP  = W'(op);
        @(negedge Clock);
        #1;
    endtask

    task automatic flags(input string tag, input bit z, input bit n, input bit c, input bit v);
        check({tag, "_Zf"}, int'(Zf), int'(z));
        check({tag, "_Nf"}, int'(Nf), int'(n));
        check({tag, "_Cf"}, int'(Cf), int'(c));
        check({tag, "_Vf"}, int'(Vf), int'(v));
    endtask

    initial begin
        bit seen;
        int lat;
        repeat (2) @(negedge Clock);
        #1;
        check("rst_RES", int'(RES), 0);
        check("rst_Busy", int'(Busy), 0);
        check("rst_Done", int'(Done), 0);
        flags("rst", 0, 0, 0, 0);
        Reset  = 1'b0;
        chk_en = 1'b1;

        // 1: 0x3FF + 1 wraps to zero with carry
        Gout = 1'b1;
        step(1, 0, 0, 'h3FF);
        step(0, 1, 0, 'h001);
        check("add_wrap_RES", int'(RES), 'h000);
        flags("add_wrap", 1, 0, 1, 0);
        Gout = 1'b0; #1;
        check("gout0_RES", int'(RES), 0);
        Gout = 1'b1;

        // 2: borrow and signed overflow
        step(1, 0, 0, 5);
        step(0, 1, 1, 7);
        check("sub_RES", int'(RES), 'h3FE);
        flags("sub", 0, 1, 0, 0);
        step(1, 0, 0, 'h1FF);
        step(0, 1, 0, 1);
        check("addv_RES", int'(RES), 'h200);
        flags("addv", 0, 1, 0, 1);
        Gout = 1'b0; #1;
        check("gout0b_RES", int'(RES), 0);
        Gout = 1'b1;

        // 3: 25*30 with ignored Ain/Gin pulses while busy
        step(1, 0, 0, 25);
        step(0, 1, 9, 30);
        check("mul_busy_first", int'(Busy), 1);
        for (int i = 1; i <= 9; i++) begin
            step((i == 3) || $urandom_range(0, 1) == 1, (i == 5) || $urandom_range(0, 1) == 1,
                 0, int'($urandom) & MASK);
            check("mul_busy", int'(Busy), 1);
            check("mul_nodone", int'(Done), 0);
            check("mul_G_held", int'(RES), 'h200);
        end
        step(0, 0, 0, 0);
        check("mul_done", int'(Done), 1);
        check("mul_busy_end", int'(Busy), 0);
        check("mul_RES", int'(RES), 750);
        flags("mul", 0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("mul_done_pulse", int'(Done), 0);
        step(0, 1, 0, 0);
        check("A_kept_RES", int'(RES), 25);

        step(1, 0, 0, 40);
        step(0, 1, 9, 40);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            lat++;
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        check("mul2_done_seen", int'(seen), 1);
        check("mul2_latency", lat, 10);
        check("mul2_RES", int'(RES), 576);
        check("mul2_Cf", int'(Cf), 1);
        // Gin in the Done cycle is accepted
        step(0, 1, 10, 'h155);
        check("gin_on_done_RES", int'(RES), 'h155);

        // 4: shifts
        step(1, 0, 0, 'h201);
        step(0, 1, 8, 0);
        check("asr_RES", int'(RES), 'h300);
        check("asr_Cf", int'(Cf), 1);
        step(0, 1, 7, 0);
        check("shr_RES", int'(RES), 'h100);
        check("shr_Cf", int'(Cf), 1);
        step(0, 1, 6, 0);
        check("shl_RES", int'(RES), 'h002);
        check("shl_Cf", int'(Cf), 1);

        // 5: Ain+Gin together, CMP, reserved
        step(1, 0, 0, 3);
        step(1, 1, 0, 9);
        check("ain_gin_RES", int'(RES), 12);
        step(0, 1, 11, 9);
        check("cmp_RES", int'(RES), 12);
        flags("cmp", 1, 0, 1, 0);
        step(0, 1, 13, 'h3FF);
        check("rsv_RES", int'(RES), 12);
        flags("rsv", 1, 0, 1, 0);
        Gout = 1'b0; #1;
        check("gout0c_RES", int'(RES), 0);
        Gout = 1'b1;

        // 6: reset aborts a multiply
        step(1, 0, 0, 25);
        step(0, 1, 9, 30);
        repeat (3) step(0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        check("abort_Busy", int'(Busy), 0);
        check("abort_Done", int'(Done), 0);
        check("abort_RES", int'(RES), 0);
        flags("abort", 0, 0, 0, 0);
        step(0, 0, 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0);
            check("abort_no_done", int'(Done), 0);
        end
        step(1, 0, 0, 3);
        step(0, 1, 9, 4);
        repeat (9) step(0, 0, 0, 0);
        check("mul34_busy", int'(Busy), 1);
        step(0, 0, 0, 0);
        check("mul34_done", int'(Done), 1);
        check("mul34_RES", int'(RES), 12);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            Gout = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), int'($urandom) & MASK);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
